// File: rtl/apb3_pixel_fifo_if.sv
// APB3 slave-slot bus bundle for the pixel FIFO.
// The interconnect side (master) drives the request; the FIFO (slave) answers.
interface apb3_pixel_fifo_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  // valid/ready: a transfer completes on the PCLK edge where PSEL & PENABLE & PREADY are all high.
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb3_pixel_fifo.sv
// APB3 slave that captures a non-stallable pixel stream into a FIFO drained
// by reading DATA, with a level IRQ on fill threshold or overflow.
module apb3_pixel_fifo #(
  parameter int PIX_WIDTH  = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  apb3_pixel_fifo_if.slave     apb,
  input  logic                 PIX_VALID,
  input  logic [PIX_WIDTH-1:0] PIX_DATA,
  input  logic                 PIX_SOF,
  output logic                 IRQ
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_next;
  logic [DEPTH_LOG2:0]   thresh, thresh_next;
  logic                  overflow, overflow_next;
  logic                  enable, enable_next;
  logic                  irq_en, irq_en_next;
  logic                  irq_next;

  logic        access, rd_access, wr_access;
  logic [2:0]  reg_sel;
  logic        empty, full;
  logic        pop, push, push_req, flush;
  logic [31:0] entry;
  logic [31:0] status_word;
  logic [31:0] rd_mux;
  logic        rd_err;

  assign access    = apb.PSEL & apb.PENABLE;
  assign rd_access = access & ~apb.PWRITE;
  assign wr_access = access & apb.PWRITE;
  assign reg_sel   = apb.PADDR[4:2];

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign flush    = wr_access & (reg_sel == 3'd2) & apb.PWDATA[1];
  assign pop      = rd_access & (reg_sel == 3'd0) & ~empty & ~flush;
  assign push_req = PIX_VALID & enable;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop) & ~flush;
  assign entry    = {PIX_SOF, 7'b0, 24'(PIX_DATA)};

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push & ~pop) begin
      count_next = count + 1'b1;
    end else if (pop & ~push) begin
      count_next = count - 1'b1;
    end
  end

  always_comb begin
    overflow_next = overflow;
    if (wr_access && reg_sel == 3'd1 && apb.PWDATA[2]) overflow_next = 1'b0;
    // A dropped pixel in the same cycle as a clear still leaves the flag set.
    if (push_req && full && !pop) overflow_next = 1'b1;
  end

  always_comb begin
    enable_next = enable;
    irq_en_next = irq_en;
    thresh_next = thresh;
    if (wr_access && reg_sel == 3'd2) begin
      enable_next = apb.PWDATA[0];
      irq_en_next = apb.PWDATA[2];
    end
    if (wr_access && reg_sel == 3'd3) thresh_next = apb.PWDATA[DEPTH_LOG2:0];
  end

  assign irq_next = irq_en_next &
                    (((thresh_next != '0) && (count_next >= thresh_next)) | overflow_next);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      thresh   <= '0;
      IRQ      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      overflow <= overflow_next;
      enable   <= enable_next;
      irq_en   <= irq_en_next;
      thresh   <= thresh_next;
      IRQ      <= irq_next;
    end
  end

  // Storage carries no reset; only pointer/count state defines validity.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_comb begin
    status_word = '0;
    status_word[0] = empty;
    status_word[1] = full;
    status_word[2] = overflow;
    status_word[8+DEPTH_LOG2:8] = count;
  end

  always_comb begin
    rd_mux = '0;
    rd_err = 1'b0;
    case (reg_sel)
      3'd0: begin
        if (apb.PWRITE) begin
          rd_err = 1'b1;
        end else if (empty) begin
          rd_err = 1'b1;
        end else begin
          rd_mux = mem[rd_ptr];
        end
      end
      3'd1:    rd_mux = status_word;
      3'd2:    rd_mux = {29'b0, irq_en, 1'b0, enable};
      3'd3:    rd_mux = {{(31-DEPTH_LOG2){1'b0}}, thresh};
      default: rd_mux = '0;
    endcase
  end

  // Reset forces a clean, error-free completion of any access in flight.
  assign apb.PRDATA  = (rd_access & PRESETN) ? rd_mux : 32'h0;
  assign apb.PSLVERR = access & PRESETN & rd_err;
  assign apb.PREADY  = 1'b1;

endmodule

// File: tb/tb_apb3_pixel_fifo.sv
// Directed bench for apb3_pixel_fifo: a vector table for basic register and
// FIFO behaviour, plus hand sequences for full/overflow, IRQ, flush and reset.
module tb_apb3_pixel_fifo;

  localparam int PW = 8;
  localparam int DL = 4;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_PUSH = 2'd2;
  localparam logic [1:0] K_IRQ  = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  pix;
    logic        sof;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  logic          PCLK = 1'b0;
  logic          PRESETN;
  logic          PIX_VALID;
  logic [PW-1:0] PIX_DATA;
  logic          PIX_SOF;
  logic          IRQ;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  apb3_pixel_fifo_if bus ();

  apb3_pixel_fifo #(.PIX_WIDTH(PW), .DEPTH_LOG2(DL)) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .apb       (bus),
    .PIX_VALID (PIX_VALID),
    .PIX_DATA  (PIX_DATA),
    .PIX_SOF   (PIX_SOF),
    .IRQ       (IRQ)
  );

  // Clock and reset
  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks: all start and end at 1 time unit after a rising edge.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic pv, input logic [7:0] pd, input logic ps,
                     output logic [31:0] rdata, output logic err);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    PIX_VALID = pv; PIX_DATA = pd; PIX_SOF = ps;
    @(negedge PCLK);
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    PIX_VALID = 1'b0; PIX_SOF = 1'b0;
  endtask

  task automatic push_pixel(input logic [7:0] d, input logic sof);
    PIX_VALID = 1'b1; PIX_DATA = d; PIX_SOF = sof;
    @(posedge PCLK); #1;
    PIX_VALID = 1'b0; PIX_SOF = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] addr,
                          input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    apb(1'b0, addr, 32'h0, 1'b0, 8'h0, 1'b0, rd, er);
    check({name, " rdata"}, rd, exp);
    check({name, " pslverr"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    apb(1'b1, addr, wdata, 1'b0, 8'h0, 1'b0, rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    PRESETN = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    PIX_VALID = 1'b0; PIX_DATA = '0; PIX_SOF = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETN = 1'b1;
    @(posedge PCLK); #1;

    check("reset irq", {31'b0, IRQ}, 32'h0);
    check("pready", {31'b0, bus.PREADY}, 32'h1);

    // Vector table: basic register map and ordered drain.
    vecs.push_back('{K_RD,   8'h04, 32'h0, 8'h00, 1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back('{K_IRQ,  8'h00, 32'h0, 8'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_WR,   8'h08, 32'h1, 8'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_PUSH, 8'h00, 32'h0, 8'h11, 1'b1, 32'h0,         1'b0});
    vecs.push_back('{K_PUSH, 8'h00, 32'h0, 8'h22, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_PUSH, 8'h00, 32'h0, 8'h33, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_RD,   8'h04, 32'h0, 8'h00, 1'b0, 32'h0000_0300, 1'b0});
    vecs.push_back('{K_RD,   8'h00, 32'h0, 8'h00, 1'b0, 32'h8000_0011, 1'b0});
    vecs.push_back('{K_RD,   8'h00, 32'h0, 8'h00, 1'b0, 32'h0000_0022, 1'b0});
    vecs.push_back('{K_RD,   8'h03, 32'h0, 8'h00, 1'b0, 32'h0000_0033, 1'b0});
    vecs.push_back('{K_RD,   8'h00, 32'h0, 8'h00, 1'b0, 32'h0,         1'b1});
    vecs.push_back('{K_WR,   8'h00, 32'hFF, 8'h00, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{K_RD,   8'h08, 32'h0, 8'h00, 1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back('{K_WR,   8'h08, 32'h7, 8'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_RD,   8'h08, 32'h0, 8'h00, 1'b0, 32'h0000_0005, 1'b0});
    vecs.push_back('{K_WR,   8'h08, 32'h1, 8'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_WR,   8'h0C, 32'hFF, 8'h00, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{K_RD,   8'h0C, 32'h0, 8'h00, 1'b0, 32'h0000_001F, 1'b0});
    vecs.push_back('{K_WR,   8'h0C, 32'h0, 8'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_WR,   8'h1C, 32'hFFFF_FFFF, 8'h00, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{K_RD,   8'h1C, 32'h0, 8'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{K_RD,   8'h04, 32'h0, 8'h00, 1'b0, 32'h0000_0001, 1'b0});

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_WR: begin
          apb(1'b1, vecs[i].addr, vecs[i].wdata, 1'b0, 8'h0, 1'b0, rd, er);
          check($sformatf("vec%0d pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
        end
        K_RD: rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp, vecs[i].exp_err);
        K_PUSH: push_pixel(vecs[i].pix, vecs[i].sof);
        default: check($sformatf("vec%0d irq", i), {31'b0, IRQ}, vecs[i].exp);
      endcase
    end

    // Fill past capacity: pixels 0x40..0x4F stored, 0x50/0x51 dropped.
    for (int i = 0; i < 18; i++) push_pixel(8'h40 + 8'(i), 1'b0);
    rd_check("full status", 8'h04, 32'h0000_1006, 1'b0);
    rd_check("full head", 8'h00, 32'h0000_0040, 1'b0);
    wr_reg(8'h04, 32'h4);
    rd_check("ovf cleared", 8'h04, 32'h0000_0F00, 1'b0);
    push_pixel(8'hA0, 1'b0);
    // Full FIFO, pop and push on the same edge.
    apb(1'b0, 8'h00, 32'h0, 1'b1, 8'hB0, 1'b0, rd, er);
    check("pop+push rdata", rd, 32'h0000_0041);
    rd_check("pop+push status", 8'h04, 32'h0000_1002, 1'b0);
    for (int i = 0; i < 14; i++)
      rd_check($sformatf("drain%0d", i), 8'h00, 32'h42 + 32'(i), 1'b0);
    rd_check("drain A0", 8'h00, 32'h0000_00A0, 1'b0);
    rd_check("drain B0", 8'h00, 32'h0000_00B0, 1'b0);
    rd_check("drained status", 8'h04, 32'h0000_0001, 1'b0);

    // Threshold interrupt.
    wr_reg(8'h0C, 32'h4);
    wr_reg(8'h08, 32'h5);
    for (int i = 0; i < 3; i++) push_pixel(8'h60 + 8'(i), 1'b0);
    check("irq below thresh", {31'b0, IRQ}, 32'h0);
    push_pixel(8'h63, 1'b0);
    check("irq at thresh", {31'b0, IRQ}, 32'h1);
    rd_check("irq pop", 8'h00, 32'h0000_0060, 1'b0);
    check("irq after pop", {31'b0, IRQ}, 32'h0);

    // Back to 5 entries, then flush with a concurrent pixel.
    push_pixel(8'h64, 1'b0);
    push_pixel(8'h65, 1'b0);
    check("irq 5 entries", {31'b0, IRQ}, 32'h1);
    apb(1'b1, 8'h08, 32'h3, 1'b1, 8'h66, 1'b0, rd, er);
    check("flush irq", {31'b0, IRQ}, 32'h0);
    rd_check("flush status", 8'h04, 32'h0000_0001, 1'b0);
    rd_check("flush ctrl", 8'h08, 32'h0000_0001, 1'b0);

    // Reset mid-capture with a DATA read in its access phase.
    wr_reg(8'h08, 32'h5);
    for (int i = 0; i < 4; i++) push_pixel(8'h70 + 8'(i), 1'b0);
    check("irq pre reset", {31'b0, IRQ}, 32'h1);
    PIX_VALID = 1'b1; PIX_DATA = 8'h7F;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 8'h00;
    #2 PRESETN = 1'b0;
    #1;
    check("async irq", {31'b0, IRQ}, 32'h0);
    check("reset prdata", bus.PRDATA, 32'h0);
    check("reset pslverr", {31'b0, bus.PSLVERR}, 32'h0);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; PIX_VALID = 1'b0;
    #2 PRESETN = 1'b1;
    @(posedge PCLK); #1;
    rd_check("post reset ctrl", 8'h08, 32'h0, 1'b0);
    rd_check("post reset thresh", 8'h0C, 32'h0, 1'b0);
    push_pixel(8'h99, 1'b0);
    rd_check("disabled capture", 8'h04, 32'h0000_0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
